// File: rtl/rr_bus_arbiter8_if.sv
// Shared-bus arbitration interface for rr_bus_arbiter8.
// Requester side (master) drives the request vector and the eight data
// lanes; the arbiter (slave) returns grant, owner index, valid and the
// selected bus value. The lock signal exists only when ARB_LOCK_EN is defined.
interface rr_bus_arbiter8_if;
  logic [7:0] req;
  logic [7:0] i0, i1, i2, i3, i4, i5, i6, i7;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       valid;
  logic [7:0] y;
`ifdef ARB_LOCK_EN
  logic       lock;

  modport master (
    output req, i0, i1, i2, i3, i4, i5, i6, i7, lock,
    input  gnt, sel, valid, y
  );

  modport slave (
    input  req, i0, i1, i2, i3, i4, i5, i6, i7, lock,
    output gnt, sel, valid, y
  );
`else
  modport master (
    output req, i0, i1, i2, i3, i4, i5, i6, i7,
    input  gnt, sel, valid, y
  );

  modport slave (
    input  req, i0, i1, i2, i3, i4, i5, i6, i7,
    output gnt, sel, valid, y
  );
`endif
endinterface

// File: rtl/rr_bus_arbiter8.sv
// 8-way round-robin arbiter for one shared 8-bit bus.
// An owner keeps the bus until it drops its request or has held it for
// MAX_HOLD cycles; the next owner is picked in the same cycle, so there is
// no idle bubble between owners. Grant, owner index and valid are registered;
// the bus value y is a combinational 8:1 mux on the registered owner.
// Optional feature: define ARB_LOCK_EN to add a lock input that freezes the
// hold counter (no timeout) while the owner keeps requesting.
module rr_bus_arbiter8 #(
  parameter int MAX_HOLD = 4   // legal 1..16
) (
  input  logic           clk,
  input  logic           rst_n,
  rr_bus_arbiter8_if.slave bus
);

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t     r_state;
  logic [7:0] r_gnt;
  logic [2:0] r_sel;
  logic [2:0] r_ptr;
  logic [3:0] r_hold;

  logic [7:0] w_data [8];
  logic       w_locked;
  logic       w_timeout;
  logic       w_release;
  logic [2:0] w_base;
  logic [7:0] w_rot;
  logic       w_found;
  logic [2:0] w_pick;

  assign w_data[0] = bus.i0;
  assign w_data[1] = bus.i1;
  assign w_data[2] = bus.i2;
  assign w_data[3] = bus.i3;
  assign w_data[4] = bus.i4;
  assign w_data[5] = bus.i5;
  assign w_data[6] = bus.i6;
  assign w_data[7] = bus.i7;

`ifdef ARB_LOCK_EN
  // Lock only matters while the owner is still asking for the bus.
  assign w_locked = bus.lock & bus.req[r_sel] & (r_state == GRANT);
`else
  assign w_locked = 1'b0;
`endif

  assign w_timeout = (r_hold == HOLD_LAST) & ~w_locked;
  assign w_release = (r_state == GRANT) & (~bus.req[r_sel] | w_timeout);

  // On release the search starts just past the outgoing owner, so a lone
  // requester that timed out wraps back around to itself.
  assign w_base = w_release ? (r_sel + 3'd1) : r_ptr;

  // Rotate the request vector so position 0 is the highest priority.
  for (genvar k = 0; k < 8; k++) begin : g_rot
    assign w_rot[k] = bus.req[w_base + 3'(k)];
  end

  // First set bit of the rotated vector, mapped back to a requester index.
  always_comb begin
    w_found = 1'b0;
    w_pick  = w_base;
    for (int k = 7; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_found = 1'b1;
        w_pick  = w_base + 3'(k);
      end
    end
  end

  // Arbitration FSM: IDLE waits for any request, GRANT keeps or hands over.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_gnt   <= 8'h00;
      r_sel   <= 3'd0;
      r_ptr   <= 3'd0;
      r_hold  <= 4'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state <= GRANT;
            r_sel   <= w_pick;
            r_gnt   <= 8'b1 << w_pick;
            r_hold  <= 4'd0;
          end
        end
        GRANT: begin
          if (!w_release) begin
            if (!w_locked) r_hold <= r_hold + 4'd1;
          end else begin
            r_ptr <= r_sel + 3'd1;
            if (w_found) begin
              r_sel  <= w_pick;
              r_gnt  <= 8'b1 << w_pick;
              r_hold <= 4'd0;
            end else begin
              r_state <= IDLE;
              r_gnt   <= 8'h00;
              r_hold  <= 4'd0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= 8'h00;
        end
      endcase
    end
  end

  assign bus.gnt   = r_gnt;
  assign bus.sel   = r_sel;
  assign bus.valid = (r_state == GRANT);
  assign bus.y     = (r_state == GRANT) ? w_data[r_sel] : 8'h00;

endmodule

// File: tb/tb_rr_bus_arbiter8.sv
// Bench for rr_bus_arbiter8: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model
// that tracks owner, tenure (cycles held) and the round-robin start point.
// Define ARB_LOCK_EN to also exercise the lock input.
module tb_rr_bus_arbiter8;
  localparam int MAX_HOLD = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       lock;
  logic       lk;
  logic [7:0] d [8];

  int n_cmp = 0;
  int n_bad = 0;

  rr_bus_arbiter8_if bus();

  assign bus.req = req;
  assign bus.i0 = d[0];
  assign bus.i1 = d[1];
  assign bus.i2 = d[2];
  assign bus.i3 = d[3];
  assign bus.i4 = d[4];
  assign bus.i5 = d[5];
  assign bus.i6 = d[6];
  assign bus.i7 = d[7];
`ifdef ARB_LOCK_EN
  assign bus.lock = lock;
  assign lk = lock;
`else
  assign lk = 1'b0;
`endif

  rr_bus_arbiter8 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    bit vld;
    int own;   // current (or last) owner
    int nxt;   // where the next search begins
    int ten;   // cycles the owner has held the bus so far
  } mstate_t;

  mstate_t ms;

  function automatic mstate_t step(input mstate_t s, input logic [7:0] r, input bit l);
    mstate_t n;
    bit handover;
    bit held;
    n = s;
    handover = 1'b0;
    if (s.vld) begin
      held = l && r[s.own];
      if (!r[s.own] || (!held && s.ten >= MAX_HOLD)) begin
        handover = 1'b1;
        n.nxt = (s.own + 1) % 8;
      end else if (!held) begin
        n.ten = s.ten + 1;
      end
    end
    if (!s.vld || handover) begin
      n.vld = 1'b0;
      for (int k = 0; k < 8; k++) begin
        if (r[(n.nxt + k) % 8]) begin
          n.vld = 1'b1;
          n.own = (n.nxt + k) % 8;
          n.ten = 1;
          break;
        end
      end
    end
    return n;
  endfunction

  // Model advances on the same edge as the design and resets asynchronously.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ms <= '0;
    else        ms <= step(ms, req, lk);
  end

  // Every-cycle comparison, a little after the falling edge.
  always begin
    @(negedge clk);
    #1;
    chk("gnt",   {24'b0, bus.gnt},   ms.vld ? 32'(1 << ms.own) : 32'd0);
    chk("sel",   {29'b0, bus.sel},   32'(ms.own));
    chk("valid", {31'b0, bus.valid}, {31'b0, ms.vld});
    chk("y",     {24'b0, bus.y},     ms.vld ? {24'b0, d[ms.own]} : 32'd0);
  end

  task automatic lit(input string nm, input logic [7:0] eg);
    chk(nm, {24'b0, bus.gnt}, {24'b0, eg});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 8'h00;
    lock  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  int mode;

  initial begin
    rst_n = 1'b0;
    req   = 8'h00;
    lock  = 1'b0;
    for (int k = 0; k < 8; k++) d[k] = 8'(8'h10 * k + k);
    #2;
    chk("rst_gnt",   {24'b0, bus.gnt},   32'd0);
    chk("rst_valid", {31'b0, bus.valid}, 32'd0);
    chk("rst_sel",   {29'b0, bus.sel},   32'd0);
    chk("rst_y",     {24'b0, bus.y},     32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Two requesters alternate every MAX_HOLD cycles.
    d[0] = 8'hA0; d[2] = 8'hA2; req = 8'h05;
    @(negedge clk);
    lit("s29_first", 8'h01);
    chk("s29_y0", {24'b0, bus.y}, 32'hA0);
    repeat (4) @(negedge clk);
    lit("s29_second", 8'h04);
    chk("s29_y2", {24'b0, bus.y}, 32'hA2);
    repeat (4) @(negedge clk);
    lit("s29_back", 8'h01);

    // Owner drops its request: handover with no idle cycle.
    do_reset();
    req = 8'h28;
    @(negedge clk);
    lit("s31_own3", 8'h08);
    @(negedge clk);
    lit("s31_own3b", 8'h08);
    req = 8'h20;
    @(negedge clk);
    lit("s31_own5", 8'h20);
    chk("s31_valid", {31'b0, bus.valid}, 32'd1);

    // All request: full rotation, four cycles each.
    do_reset();
    req = 8'hFF;
    for (int g = 0; g < 9; g++)
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        lit("s32_rot", 8'(1 << (g % 8)));
      end

    // Lone requester 7 is re-granted across timeouts with no gap.
    do_reset();
    req = 8'h80;
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      lit("s30_hold", 8'h80);
      chk("s30_sel", {29'b0, bus.sel}, 32'd7);
    end

    // Asynchronous reset mid-grant, then restart from requester 0.
    do_reset();
    req = 8'h40;
    repeat (2) @(negedge clk);
    lit("s33_own6", 8'h40);
    #2 rst_n = 1'b0;
    #1;
    lit("s33_gnt0", 8'h00);
    chk("s33_valid0", {31'b0, bus.valid}, 32'd0);
    chk("s33_y0", {24'b0, bus.y}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    req = 8'hFF;
    @(negedge clk);
    lit("s33_first0", 8'h01);

`ifdef ARB_LOCK_EN
    // Locked owner keeps the bus; timeout resumes from the frozen count.
    do_reset();
    lock = 1'b1;
    req  = 8'h06;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      lit("s34_locked", 8'h02);
    end
    lock = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      lit("s34_resume", 8'h02);
    end
    @(negedge clk);
    lit("s34_pass", 8'h04);
`endif

    // Randomized traffic, checked by the every-cycle compare.
    do_reset();
    mode = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (c % 64 == 0) mode = int'($urandom_range(0, 3));
      for (int k = 0; k < 8; k++) d[k] = 8'($urandom);
      case (mode)
        0: req = 8'($urandom);
        1: req = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'(1 << $urandom_range(0, 7));
        2: req = ($urandom_range(0, 15) == 0) ? 8'(~(1 << $urandom_range(0, 7))) : 8'hFF;
        default: if ($urandom_range(0, 3) == 0) req = req ^ 8'(1 << $urandom_range(0, 7));
      endcase
      if ($urandom_range(0, 7) == 0) lock = ~lock;
      rst_n = ($urandom_range(0, 399) != 0);
    end
    rst_n = 1'b1;
    req = 8'h00;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rr_bus_arbiter8.md
RR_BUS_ARBITER8 -- requirements
Module: rr_bus_arbiter8

Interface
REQ-001 Parameter: MAX_HOLD, 4, maximum consecutive cycles one requester may hold the grant; legal range 1..16.
REQ-002 Port: clk  in  1  rising-edge clock; sole clock domain.
REQ-003 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-004 Port: req  in  8  request vector; bit k = requester k wants the shared 8-bit bus.
REQ-005 Port: i0..i7  in  8 each  data from requesters 0..7.
REQ-006 Port: gnt  out  8  one-hot registered grant; all zero when no owner.
REQ-007 Port: sel  out  3  registered binary index of the current owner; drives the 8:1 select.
REQ-008 Port: valid  out  1  registered; 1 while a grant is held.
REQ-009 Port: y  out  8  shared bus; combinational, equals i[sel] when valid=1, else 8'h00.
REQ-010 Port: lock  in  1  present only when ARB_LOCK_EN is defined (see Configuration).

Function
REQ-011 States: IDLE (no owner) and GRANT (one owner); the state is encoded in valid.
REQ-012 The block shall keep a 3-bit round-robin pointer ptr; the search order is ptr, ptr+1, ... ptr+7, modulo 8.
REQ-013 IDLE: when req != 0, on the next edge the block shall grant the first requesting index in search order; it shall go to GRANT with valid=1 and hold_cnt=0. Latency from req sampled to gnt visible is 1 cycle.
REQ-014 IDLE with req == 0 shall remain IDLE, with outputs unchanged at gnt=0, valid=0 and sel holding its last value.
REQ-015 GRANT: hold_cnt (4-bit) shall increment each cycle that the owner is retained.
REQ-016 Release condition: req[sel]==0, or hold_cnt==MAX_HOLD-1.
REQ-017 On release, ptr shall become sel+1 modulo 8 (7 wraps to 0).
REQ-018 In the same release cycle, the next owner shall be chosen from the current req using the updated ptr. There is no idle bubble: the new gnt is visible on the next edge.
REQ-019 If a release occurs and no requester qualifies, the block shall go to IDLE on the next edge.
REQ-020 On a timeout release, if the owner is still the only requester, the search wraps back to it. It shall be re-granted with hold_cnt=0, and ptr still advances.
REQ-021 Simultaneous requests: exactly one bit of gnt shall be set; the winner is strictly the first index in search order.
REQ-022 A request that arrives in the same cycle as a release shall be eligible in that arbitration.
REQ-023 gnt shall always equal 1<<sel when valid=1, and 8'h00 when valid=0.

Reset
REQ-024 rst_n=0 shall immediately force gnt=8'h00, sel=3'd0, valid=0, ptr=3'd0, hold_cnt=0 and state IDLE, independent of clk.
REQ-025 Reset asserted mid-grant shall drop the grant immediately. After deassertion, arbitration shall restart from ptr=0.
REQ-026 The first edge after rst_n rises shall behave as IDLE.

Configuration
REQ-027 Macro ARB_LOCK_EN. When it is defined, the lock input exists. While lock=1 and req[sel]=1, hold_cnt shall freeze and the timeout shall be suppressed, so the owner keeps the bus indefinitely. Dropping req[sel] still releases the grant.
REQ-028 When ARB_LOCK_EN is undefined, the lock port is absent and the timeout of REQ-016 always applies.

Verification
REQ-029 Scenario: after reset, req=8'b0000_0101 with i0=8'hA0 and i2=8'hA2 -> cycle+1: gnt=8'h01, y=8'hA0. After 4 cycles: gnt=8'h04, y=8'hA2. After 4 more cycles: gnt=8'h01 again.
REQ-030 Scenario: req=8'h80 held alone with MAX_HOLD=4 -> gnt=8'h80 continuously, sel=7. ptr wraps to 0 at each timeout and the owner is re-granted with no valid gap.
REQ-031 Scenario: owner 3 drops req after 2 cycles while req[5]=1 -> the next edge shows gnt=8'h20 with no idle cycle.
REQ-032 Scenario: req=8'hFF held -> grants rotate 0,1,...,7,0, each lasting 4 cycles; exactly one gnt bit is set in every cycle.
REQ-033 Scenario: rst_n pulsed low mid-grant of owner 6 -> gnt=0, valid=0 and y=8'h00 with no clock edge. After release, with req=8'hFF, owner 0 is granted first.
REQ-034 Scenario (ARB_LOCK_EN defined): owner 1 holds with lock=1 for 10 cycles while req[2]=1 -> gnt stays 8'h02. When lock falls, timeout resumes from the frozen count and the grant passes to owner 2.
